// File: rtl/latealu_pkg.sv
// Shared definitions for the late ALU: opcodes, FSM state encoding and a
// conditional-negate helper used for operand magnitudes and sign correction.
// The helper works on a 128-bit container, so WIDTH is limited to 64
// (2*WIDTH must fit for full-width product negation).
package latealu_pkg;

  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_MULT  = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000101;
  localparam logic [5:0] OP_MTLO  = 6'b000110;
  localparam logic [5:0] OP_MULTU = 6'b000111;
  localparam logic [5:0] OP_DIV   = 6'b001000;
  localparam logic [5:0] OP_DIVU  = 6'b001001;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  localparam int unsigned MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  // Two's-complement negate when neg is set; callers truncate to their width.
  function automatic wide_t cond_neg(input wide_t v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/latealu_iter_core.sv
// Iterative multiply/divide datapath: one radix-2 step per cycle on unsigned
// magnitudes. acc/q form a 2*WIDTH shift pair; after WIDTH steps
//   multiply: {hi_raw,lo_raw} = a_mag * b_mag
//   divide:   lo_raw = a_mag / b_mag, hi_raw = a_mag % b_mag (restoring)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture a_mag (multiplier/dividend) and b_mag, clear acc
//   step            perform one iteration
//   mode_div        1 = divide step, 0 = multiply step (only when
//                   LATEALU_DIV_EN is defined; otherwise multiply only)
//   a_mag, b_mag    unsigned operand magnitudes
//   hi_raw, lo_raw  unsigned result pair
module latealu_iter_core
  import latealu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
`ifdef LATEALU_DIV_EN
  input  logic             mode_div,
`endif
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi_raw,
  output logic [WIDTH-1:0] lo_raw
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;

`ifdef LATEALU_DIV_EN
  // One adder serves both modes: acc + (q[0] ? m : 0) for multiply,
  // rem + ~m + 1 for divide, where the carry out means rem >= m.
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   opa;
  logic [WIDTH:0]   opb;
  logic [WIDTH+1:0] sum;

  always_comb begin
    rem = {acc, q[WIDTH-1]};
    opa = mode_div ? rem : {1'b0, acc};
    opb = mode_div ? ~{1'b0, m} : (q[0] ? {1'b0, m} : '0);
    sum = {1'b0, opa} + {1'b0, opb} + {{(WIDTH+1){1'b0}}, mode_div};
  end
`else
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= '0;
      q   <= a_mag;
      m   <= b_mag;
    end else if (step) begin
`ifdef LATEALU_DIV_EN
      if (mode_div) begin
        acc <= sum[WIDTH+1] ? sum[WIDTH-1:0] : rem[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], sum[WIDTH+1]};
      end else
`endif
      begin
        {acc, q} <= {sum[WIDTH:0], q[WIDTH-1:1]};
      end
    end
  end

  assign hi_raw = acc;
  assign lo_raw = q;

endmodule

// File: rtl/pipeline_latealu_iter.sv
// Late ALU after EX: registered srl/sra, mthi/mtlo, and iterative
// mult/multu (and div/divu when LATEALU_DIV_EN is defined) writing HI/LO.
// Long ops run IDLE -> MUL/DIV (WIDTH steps) -> FIX -> IDLE and block issue;
// flush abandons a long op without touching HI/LO.
// Configuration macro: LATEALU_DIV_EN (divider present when defined).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      op/a0/a1 valid; in_ready: unit can accept (transfer on both)
//   op            6-bit operation code
//   a0, a1        operands (rs/dividend, rt/divisor); a1 low bits = shamt
//   flush         kill in-flight long op
//   result_out    shift result; result_valid one-cycle update pulse
//   hi, lo        HI/LO registers; hilo_busy: HI/LO write pending
module pipeline_latealu_iter
  import latealu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             flush,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hilo_busy
);

  state_t state;
  state_t state_nxt;

  logic [SHAMT_W-1:0] cnt;
  logic               transfer;
  logic               is_mul;
  logic               is_long;
  logic               op_signed;
  logic               sgn_a;
  logic               sgn_b;
  logic               neg_a;
  logic               neg_b;
  logic               step;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   hi_raw;
  logic [WIDTH-1:0]   lo_raw;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;
`ifdef LATEALU_DIV_EN
  logic               is_div;
  logic               div_op;
  logic               div_zero;
  logic [WIDTH-1:0]   a0_l;
`endif

  // Decode and operand magnitudes. neg_a/neg_b latch only for signed ops,
  // so later sign correction needs no separate signed flag.
  always_comb begin
    transfer  = in_valid && in_ready;
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
`ifdef LATEALU_DIV_EN
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_long   = is_mul || is_div;
    op_signed = (op == OP_MULT) || (op == OP_DIV);
`else
    is_long   = is_mul;
    op_signed = (op == OP_MULT);
`endif
    sgn_a     = op_signed && a0[WIDTH-1];
    sgn_b     = op_signed && a1[WIDTH-1];
    a_mag     = WIDTH'(cond_neg(wide_t'(a0), sgn_a));
    b_mag     = WIDTH'(cond_neg(wide_t'(a1), sgn_b));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (is_mul) state_nxt = MUL;
`ifdef LATEALU_DIV_EN
          else if (is_div) state_nxt = DIV;
`endif
        end
      end
      MUL, DIV: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    hilo_busy = (state != IDLE);
    step      = (state == MUL) || (state == DIV);
  end

  latealu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (transfer && is_long),
    .step     (step),
`ifdef LATEALU_DIV_EN
    .mode_div (state == DIV),
`endif
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .hi_raw   (hi_raw),
    .lo_raw   (lo_raw)
  );

  // Sign correction applied in FIX. Divide-by-zero bypasses the datapath
  // result; MIN / -1 falls out naturally since |MIN| is representable
  // as an unsigned magnitude and negates back to MIN.
  always_comb begin
    {hi_fix, lo_fix} = (2*WIDTH)'(cond_neg(wide_t'({hi_raw, lo_raw}), neg_a ^ neg_b));
`ifdef LATEALU_DIV_EN
    if (div_op) begin
      if (div_zero) begin
        hi_fix = a0_l;
        lo_fix = '1;
      end else begin
        hi_fix = WIDTH'(cond_neg(wide_t'(hi_raw), neg_a));
        lo_fix = WIDTH'(cond_neg(wide_t'(lo_raw), neg_a ^ neg_b));
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_out   <= '0;
      result_valid <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      cnt          <= '0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
`ifdef LATEALU_DIV_EN
      div_op       <= 1'b0;
      div_zero     <= 1'b0;
      a0_l         <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      if (transfer) begin
        case (op)
          OP_SRL: begin
            result_out   <= a0 >> a1[SHAMT_W-1:0];
            result_valid <= 1'b1;
          end
          OP_SRA: begin
            result_out   <= $signed(a0) >>> a1[SHAMT_W-1:0];
            result_valid <= 1'b1;
          end
          OP_MTHI: hi <= a0;
          OP_MTLO: lo <= a0;
          default: ;
        endcase
        if (is_long) begin
          neg_a    <= sgn_a;
          neg_b    <= sgn_b;
          cnt      <= SHAMT_W'(WIDTH - 1);
`ifdef LATEALU_DIV_EN
          div_op   <= is_div;
          div_zero <= (a1 == '0);
          a0_l     <= a0;
`endif
        end
      end
      if (step) cnt <= cnt - SHAMT_W'(1);
      // A flush arriving during FIX still suppresses the write.
      if ((state == FIX) && !flush) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_latealu_iter.sv
module tb_pipeline_latealu_iter;

  localparam int W = 32;

  localparam logic [5:0] T_SRL   = 6'b000010;
  localparam logic [5:0] T_SRA   = 6'b000011;
  localparam logic [5:0] T_MULT  = 6'b000100;
  localparam logic [5:0] T_MTHI  = 6'b000101;
  localparam logic [5:0] T_MTLO  = 6'b000110;
  localparam logic [5:0] T_MULTU = 6'b000111;
  localparam logic [5:0] T_DIVU  = 6'b001001;
`ifdef LATEALU_DIV_EN
  localparam logic [5:0] T_DIV   = 6'b001000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   op = '0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] a1 = '0;
  logic         flush = 1'b0;
  logic [W-1:0] result_out;
  logic         result_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         hilo_busy;

  pipeline_latealu_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a0           (a0),
    .a1           (a1),
    .flush        (flush),
    .result_out   (result_out),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo),
    .hilo_busy    (hilo_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] v0;
    logic [W-1:0] v1;
  } exp_t;

  exp_t shq[$];
  exp_t hlq[$];

  int unsigned  passed = 0;
  int unsigned  total  = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  bit           mon_en = 1'b0;
  logic         prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: shift results on result_valid, HI/LO on the busy falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (result_valid) begin
        if (shq.size() == 0) begin
          check("unexpected_result_valid", 64'(result_out), 64'hDEAD);
        end else begin
          exp_t e;
          e = shq.pop_front();
          check(e.name, 64'(result_out), 64'(e.v0));
        end
      end
      if (prev_busy && !hilo_busy) begin
        if (hlq.size() == 0) begin
          check("unexpected_hilo_done", {hi, lo}, 64'hDEAD);
        end else begin
          exp_t e;
          e = hlq.pop_front();
          check(e.name, {hi, lo}, {e.v0, e.v1});
        end
      end
    end
    prev_busy = hilo_busy;
  end

  // All tasks run in the phase #1 after a rising edge.
  task automatic issue(input logic [5:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic fl);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("issue_ready_timeout", 64'(in_ready), 64'd1);
    op = o; a0 = x; a1 = y; in_valid = 1'b1; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    op = 6'h3F; a0 = $urandom; a1 = $urandom;
  endtask

  task automatic shift_op(input string name, input logic [5:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] e);
    shq.push_back('{name, e, '0});
    issue(o, x, y, 1'b0);
  endtask

  task automatic long_op(input string name, input logic [5:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic fl);
    int n;
    bit ok;
    hlq.push_back('{name, ehi, elo});
    hi_m = ehi; lo_m = elo;
    issue(o, x, y, fl);
    n = 0; ok = 1'b1;
    while (hilo_busy && n < 60) begin
      if (in_ready) ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(W + 1));
    check({name, "_stall"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    check("ready_low_in_rst", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(hilo_busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_result", {31'd0, result_valid, result_out}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Shifts
    shift_op("srl_4",       T_SRL, 32'h80000000, 32'd4,  32'h08000000);
    shift_op("sra_4",       T_SRA, 32'h80000000, 32'd4,  32'hF8000000);
    shift_op("sra_pos",     T_SRA, 32'h7FFFFFF0, 32'd4,  32'h07FFFFFF);
    shift_op("srl_0",       T_SRL, 32'hA5A5A5A5, 32'd0,  32'hA5A5A5A5);
    shift_op("sra_31",      T_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF);
    shift_op("srl_shamt_lo",T_SRL, 32'hF0000000, 32'h24, 32'h0F000000);

    // mthi / mtlo
    issue(T_MTHI, 32'hCAFE0001, '0, 1'b0);
    hi_m = 32'hCAFE0001;
    check("mthi", 64'(hi), 64'(hi_m));
    issue(T_MTLO, 32'h0BAD0002, '0, 1'b0);
    lo_m = 32'h0BAD0002;
    check("mtlo", {hi, lo}, {hi_m, lo_m});

    // Unknown op: no effect
    issue(6'b111111, 32'h11111111, 32'h22222222, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("unknown_op", {hi, lo}, {hi_m, lo_m});

    // Multiply
    long_op("mult_m1x2",  T_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    long_op("multu_m1x2", T_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    long_op("mult_m3x5",  T_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    long_op("multu_max",  T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    long_op("mult_pmax",  T_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    long_op("mult_minsq", T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    // flush coincident with the transfer does not cancel the op
    long_op("mult_flush_at_issue", T_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

`ifdef LATEALU_DIV_EN
    long_op("div_m7_2",   T_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    long_op("div_7_m2",   T_DIV,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    long_op("div_5_0",    T_DIV,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
    long_op("div_min_m1", T_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    long_op("divu_10_3",  T_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0);
`else
    issue(T_DIVU, 32'd10, 32'd3, 1'b0);
    ok = 1'b1;
    for (k = 0; k < 4; k++) begin
      if (!in_ready || hilo_busy) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("divu_nodiv_ready", 64'(ok), 64'd1);
    check("divu_nodiv_hilo", {hi, lo}, {hi_m, lo_m});
`endif

    // Flush mid-operation
    issue(T_MTHI, 32'h00001234, '0, 1'b0);
    hi_m = 32'h00001234;
    hlq.push_back('{"flush_keep", hi_m, lo_m});
    issue(T_MULT, 32'd3, 32'd4, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(hilo_busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_late_write", {hi, lo}, {hi_m, lo_m});

    // Flush while idle is ignored
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {hi, lo}, {hi_m, lo_m});

    // Reset mid-operation
    shift_op("srl_before_rst", T_SRL, 32'h0000FF00, 32'd8, 32'h000000FF);
    hlq.push_back('{"rst_clear", '0, '0});
    issue(T_MULT, 32'd9, 32'd9, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("ready_low_rst_mid", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    check("rst_mid_result", {31'd0, result_valid, result_out}, 64'd0);

    // Operation after reset still works
    long_op("mult_after_rst", T_MULTU, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(shq.size() + hlq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
